// File: rtl/nios_mem_bist_pkg.sv
// Shared types and constants for the memory BIST master and its pattern generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios_mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    FINISH
  } state_t;

  localparam logic [1:0] PAT_CONST = 2'd0;
  localparam logic [1:0] PAT_ADDR  = 2'd1;
  localparam logic [1:0] PAT_INC   = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Deepest read-return pipeline the compare path is built for
  localparam int MAX_RD_LAT = 4;

endpackage

// File: rtl/nios_mem_bist_patgen.sv
// Pattern generator: maps (pattern, seed, index, address) to the expected data word.
// Latency: combinational.
// Backpressure: none; the caller holds its inputs while a command is stalled.
module nios_mem_bist_patgen
  import nios_mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_seed,
  input  logic [ADDR_W:0]   i_idx,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_dat
);

  localparam int unsigned HALF_W = DATA_W / 2;

  logic [HALF_W-1:0] w_half;

  // Address is zero-extended or truncated into each half of the word
  assign w_half = HALF_W'(i_addr);

  // Select the pattern word for this index/address
  always_comb begin
    o_dat = i_seed;
    case (i_sel)
      PAT_CONST: o_dat = i_seed;
      PAT_ADDR:  o_dat = {~w_half, w_half};
      PAT_INC:   o_dat = i_seed + DATA_W'(i_idx);
      PAT_CHECK: o_dat = i_idx[0] ? ~i_seed : i_seed;
    endcase
  end

endmodule

// File: rtl/nios_mem_bist_master.sv
// Avalon-MM BIST master: writes a pattern over a word range, reads it back, counts mismatches.
// Latency: done pulses 2N+READ_LATENCY+1 cycles after start with no stalls (next cycle when N=0).
// Backpressure: waitrequest stalls the command; address/write/writedata hold until accepted.
module nios_mem_bist_master
  import nios_mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ERR_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  localparam int LAT = (READ_LATENCY < 1) ? 1 :
                       (int'(READ_LATENCY) > MAX_RD_LAT) ? MAX_RD_LAT : int'(READ_LATENCY);

  state_t              r_state;
  logic                r_arm;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_cnt;
  logic [1:0]          r_sel;
  logic [DATA_W-1:0]   r_seed;
  logic [ADDR_W:0]     r_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_dat;
  logic                r_cs;
  logic                r_wr;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [ERR_W-1:0]    r_err;
  logic [ADDR_W-1:0]   r_ferr;
  logic                r_pv [1:LAT];
  logic [ADDR_W-1:0]   r_pa [1:LAT];
  logic [DATA_W-1:0]   r_pe [1:LAT];

  logic                w_acc;
  logic                w_last;
  logic [ADDR_W:0]     w_nxt_idx;
  logic [ADDR_W-1:0]   w_nxt_addr;
  logic                w_mis;
  logic [ERR_W-1:0]    w_err_nxt;
  logic                w_drain_done;
  logic [1:0]          w_pg_sel;
  logic [DATA_W-1:0]   w_pg_seed;
  logic [ADDR_W:0]     w_pg_idx;
  logic [ADDR_W-1:0]   w_pg_addr;
  logic [DATA_W-1:0]   w_pg_dat;

  assign w_acc      = r_cs & ~avm_waitrequest;
  assign w_last     = (r_idx + (ADDR_W+1)'(1)) == r_cnt;
  // After the final write the walk restarts at index 0 for the read pass
  assign w_nxt_idx  = w_last ? '0 : r_idx + (ADDR_W+1)'(1);
  assign w_nxt_addr = w_last ? r_base : r_addr + ADDR_W'(1);
  assign w_mis      = r_pv[LAT] && (avm_readdata != r_pe[LAT]);
  assign w_err_nxt  = (w_mis && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;

  // Pipeline may retire once only the oldest stage (compared this cycle) can still be valid
  always_comb begin
    w_drain_done = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      if (r_pv[i]) w_drain_done = 1'b0;
    end
  end

  // One generator: fed from the ports at start, else with the next command's index/address
  always_comb begin
    w_pg_sel  = r_sel;
    w_pg_seed = r_seed;
    w_pg_idx  = w_nxt_idx;
    w_pg_addr = w_nxt_addr;
    if (r_state == IDLE) begin
      w_pg_sel  = pattern_sel;
      w_pg_seed = seed;
      w_pg_idx  = '0;
      w_pg_addr = base_addr;
    end
  end

  nios_mem_bist_patgen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_patgen (
    .i_sel  (w_pg_sel),
    .i_seed (w_pg_seed),
    .i_idx  (w_pg_idx),
    .i_addr (w_pg_addr),
    .o_dat  (w_pg_dat)
  );

  // Run sequencer, command registers and result counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_arm   <= 1'b0;
      r_base  <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_seed  <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_dat   <= '0;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_ferr  <= '0;
    end else begin
      // r_arm blocks a start coinciding with the first edge after reset release
      r_arm  <= 1'b1;
      r_done <= 1'b0;
      r_err  <= w_err_nxt;
      if (w_mis && (r_err == '0)) r_ferr <= r_pa[LAT];
      case (r_state)
        IDLE: begin
          if (start && r_arm) begin
            r_base <= base_addr;
            r_cnt  <= word_count;
            r_sel  <= pattern_sel;
            r_seed <= seed;
            r_idx  <= '0;
            r_addr <= base_addr;
            r_dat  <= w_pg_dat;
            r_err  <= '0;
            r_ferr <= '0;
            if (word_count == '0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= WRITE;
              r_pass  <= 1'b0;
              r_busy  <= 1'b1;
              r_cs    <= 1'b1;
              r_wr    <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (w_acc) begin
            r_idx  <= w_nxt_idx;
            r_addr <= w_nxt_addr;
            r_dat  <= w_pg_dat;
            if (w_last) begin
              r_wr    <= 1'b0;
              r_state <= READ;
            end
          end
        end
        READ: begin
          // r_dat doubles as the expected word for the read in flight
          if (w_acc) begin
            r_idx  <= w_nxt_idx;
            r_addr <= w_nxt_addr;
            r_dat  <= w_pg_dat;
            if (w_last) begin
              r_cs    <= 1'b0;
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_drain_done) begin
            r_state <= FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end
        end
        FINISH: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read-return tracking: each accepted read carries its address and expected word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i <= LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
        r_pe[i] <= '0;
      end
    end else begin
      r_pv[1] <= w_acc && (r_state == READ);
      r_pa[1] <= r_addr;
      r_pe[1] <= r_dat;
      for (int i = 2; i <= LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_ferr;
  assign avm_address    = r_addr;
  assign avm_byteenable = {(DATA_W/8){r_cs}};
  assign avm_chipselect = r_cs;
  assign avm_write      = r_wr;
  assign avm_writedata  = r_dat;

endmodule

// File: tb/tb_nios_mem_bist_master.sv
// Bench for the BIST master: a memory slave model, scoreboard queues and a negedge monitor.
// Two instances (read latency 1 and 3) share stimulus; only one is active per run.
// Expected commands and done results are queued by stimulus and popped by the monitor.
module tb_nios_mem_bist_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int EW = 16;

  typedef struct {
    bit             wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  dat;
  } cmd_t;

  typedef struct {
    bit             pass;
    int             err;
    logic [AW-1:0]  ferr;
    int             cyc;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            start1, start3;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     word_count;
  logic [1:0]      pattern_sel;
  logic [DW-1:0]   seed;
  logic            wreq;
  logic [DW-1:0]   rdata1, rdata3;

  logic            busy1, done1, pass1, cs1, wr1;
  logic [EW-1:0]   err1;
  logic [AW-1:0]   ferr1, addr1;
  logic [3:0]      be1;
  logic [DW-1:0]   wd1;
  logic            busy3, done3, pass3, cs3, wr3;
  logic [EW-1:0]   err3;
  logic [AW-1:0]   ferr3, addr3;
  logic [3:0]      be3;
  logic [DW-1:0]   wd3;

  nios_mem_bist_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .ERR_W(EW)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .base_addr(base_addr),
    .word_count(word_count), .pattern_sel(pattern_sel), .seed(seed),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_addr(ferr1),
    .avm_address(addr1), .avm_byteenable(be1), .avm_chipselect(cs1), .avm_write(wr1),
    .avm_writedata(wd1), .avm_readdata(rdata1), .avm_waitrequest(wreq)
  );

  nios_mem_bist_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3), .ERR_W(EW)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .base_addr(base_addr),
    .word_count(word_count), .pattern_sel(pattern_sel), .seed(seed),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .first_err_addr(ferr3),
    .avm_address(addr3), .avm_byteenable(be3), .avm_chipselect(cs3), .avm_write(wr3),
    .avm_writedata(wd3), .avm_readdata(rdata3), .avm_waitrequest(wreq)
  );

  bit            sel3 = 1'b0;
  bit            flip_en = 1'b0;
  bit            rnd_en = 1'b0;
  int            cyc = 0;
  int            vec = 0;
  int            errs = 0;
  cmd_t          cmd_q[$];
  done_t         done_q[$];

  logic          b_cs, b_wr, b_done, b_pass, b_busy;
  logic [AW-1:0] b_addr, b_ferr;
  logic [DW-1:0] b_wd;
  logic [3:0]    b_be;
  logic [EW-1:0] b_err;

  assign b_cs   = sel3 ? cs3   : cs1;
  assign b_wr   = sel3 ? wr3   : wr1;
  assign b_addr = sel3 ? addr3 : addr1;
  assign b_wd   = sel3 ? wd3   : wd1;
  assign b_be   = sel3 ? be3   : be1;
  assign b_done = sel3 ? done3 : done1;
  assign b_pass = sel3 ? pass3 : pass1;
  assign b_busy = sel3 ? busy3 : busy1;
  assign b_err  = sel3 ? err3  : err1;
  assign b_ferr = sel3 ? ferr3 : ferr1;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave memory model with fixed-latency read return; optional bit-0 corruption at 0x0005
  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] pipe [1:3];
  always @(posedge clk) begin
    if (b_cs && !wreq && b_wr) mem[b_addr] <= b_wd;
    if (b_cs && !wreq && !b_wr)
      pipe[1] <= mem[b_addr] ^ ((flip_en && b_addr == 16'h0005) ? 32'h1 : 32'h0);
    else
      pipe[1] <= 32'hDEAD_BEEF;
    pipe[2] <= pipe[1];
    pipe[3] <= pipe[2];
  end
  assign rdata1 = pipe[1];
  assign rdata3 = pipe[3];

  // Random stall generator, changes just after each rising edge
  initial begin
    wreq = 1'b0;
    forever begin
      @(posedge clk);
      #1 wreq = rnd_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [1:0] ps, input logic [DW-1:0] sd,
                                        input int i, input logic [AW-1:0] a);
    case (ps)
      2'd0:    return sd;
      2'd1:    return {~a, a};
      2'd2:    return sd + DW'(i);
      default: return (i % 2 == 1) ? ~sd : sd;
    endcase
  endfunction

  // Monitor: checks every accepted command, command stability under stall, and each done pulse
  bit            stall_q = 1'b0;
  logic          prev_wr;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wd;
  always @(negedge clk) begin
    cmd_t  ec;
    done_t ed;
    if (reset_n) begin
      if (b_cs && stall_q) begin
        chk("stall_hold_cmd", {b_wr, b_addr, b_wd}, {prev_wr, prev_addr, prev_wd});
      end
      if (b_cs && !wreq) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd_addr", {1'b1, b_addr}, 17'h0);
        end else begin
          ec = cmd_q.pop_front();
          chk("cmd_write", b_wr, ec.wr);
          chk("cmd_addr", b_addr, ec.addr);
          chk("cmd_be", b_be, 4'hF);
          if (ec.wr) chk("cmd_wdata", b_wd, ec.dat);
        end
      end
      stall_q   = b_cs && wreq;
      prev_wr   = b_wr;
      prev_addr = b_addr;
      prev_wd   = b_wd;
      if (b_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ed = done_q.pop_front();
          chk("done_pass", b_pass, ed.pass);
          chk("done_err_count", b_err, ed.err);
          chk("done_first_err", b_ferr, ed.ferr);
          chk("done_busy_low", b_busy, 0);
          if (ed.cyc >= 0) chk("done_cycle", cyc, ed.cyc);
        end
      end
    end
  end

  task automatic wait_idle(input int limit);
    for (int t = 0; t < limit && (cmd_q.size() != 0 || done_q.size() != 0); t++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    chk("timeout_pending", cmd_q.size() + done_q.size(), 0);
    cmd_q.delete();
    done_q.delete();
  endtask

  // Queue the expected traffic and result, then pulse start; rs>0 re-pulses start while busy
  task automatic run(input bit use3, input logic [AW-1:0] b, input int n, input logic [1:0] ps,
                     input logic [DW-1:0] sd, input bit ep, input int ee,
                     input logic [AW-1:0] ef, input bit timed, input int rs);
    cmd_t  c;
    done_t d;
    int    lat;
    lat = use3 ? 3 : 1;
    @(negedge clk);
    sel3 = use3;
    for (int i = 0; i < n; i++) begin
      c.wr = 1'b1; c.addr = b + AW'(i); c.dat = pat(ps, sd, i, c.addr);
      cmd_q.push_back(c);
    end
    for (int i = 0; i < n; i++) begin
      c.wr = 1'b0; c.addr = b + AW'(i); c.dat = '0;
      cmd_q.push_back(c);
    end
    d.pass = ep; d.err = ee; d.ferr = ef;
    d.cyc  = !timed ? -1 : (n == 0) ? cyc + 1 : cyc + 1 + 2 * n + lat;
    done_q.push_back(d);
    base_addr = b; word_count = (AW+1)'(n); pattern_sel = ps; seed = sd;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    if (rs > 0) begin
      repeat (rs) @(negedge clk);
      chk("busy_during_run", b_busy, 1);
      base_addr = 16'h1234; word_count = 17'd2;
      if (use3) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
    end
    wait_idle(1000);
  endtask

  initial begin
    reset_n = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    base_addr = '0; word_count = '0; pattern_sel = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_cs", cs1, 0);
    chk("rst_write", wr1, 0);
    chk("rst_err", err1, 0);
    chk("rst_ferr", ferr1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_wdata", wd1, 0);
    chk("rst_be", be1, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // {~addr,addr} pattern over 0..7, latency 1, done at k+18
    run(0, 16'h0000, 8, 2'd1, 32'h0, 1, 0, 16'h0, 1, 0);
    // Corrupted readback at 0x0005
    flip_en = 1'b1;
    run(0, 16'h0000, 16, 2'd0, 32'hA5A5_A5A5, 0, 1, 16'h0005, 1, 0);
    flip_en = 1'b0;
    // Address wrap with incrementing data
    run(0, 16'hFFFE, 4, 2'd2, 32'h10, 1, 0, 16'h0, 1, 0);
    // Zero-length run: done next cycle, no bus activity
    run(0, 16'h0040, 0, 2'd0, 32'h0, 1, 0, 16'h0, 1, 0);
    // Start while busy is ignored
    run(0, 16'h0020, 4, 2'd3, 32'h0F0F_0F0F, 1, 0, 16'h0, 1, 3);

    // Reset mid-run: outputs clear immediately, no done afterwards
    @(negedge clk);
    sel3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cmd_t c;
      c.wr = 1'b1; c.addr = 16'h0300 + AW'(i); c.dat = 32'h5555_AAAA;
      cmd_q.push_back(c);
    end
    base_addr = 16'h0300; word_count = 17'd8; pattern_sel = 2'd0; seed = 32'h5555_AAAA;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy1, 0);
    chk("midrst_cs", cs1, 0);
    chk("midrst_write", wr1, 0);
    chk("midrst_addr", addr1, 0);
    chk("midrst_wdata", wd1, 0);
    chk("midrst_be", be1, 0);
    chk("midrst_done", done1, 0);
    cmd_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);

    // Random stalls, latency 3, checkerboard over 32 words
    rnd_en = 1'b1;
    run(1, 16'h0100, 32, 2'd3, 32'h1234_5678, 1, 0, 16'h0, 0, 0);
    rnd_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/nios_mem_bist_master.md
Name: nios_mem_bist_master

Overview:
Avalon-MM master built-in self-test engine for the on-chip NIOS program/data memory slave. On a start pulse it writes a selectable data pattern over a word range, then reads the range back and compares each word against the expected value. It reports pass/fail, a saturating error count and the first failing address. It sits beside the CPU data master on the memory's second slave port and is used for board bring-up and post-reset memory checks.

Parameters:
ADDR_W, 16, word-address width; matches the memory's address port
DATA_W, 32, data width; byteenable width is DATA_W/8
READ_LATENCY, 1, fixed cycles from read acceptance to valid avm_readdata (1 to 4)
ERR_W, 16, error counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle run request; ignored while busy
base_addr  in  ADDR_W  first word address
word_count  in  ADDR_W+1  number of words; 0 is legal
pattern_sel  in  2  0=constant seed, 1={~addr,addr}, 2=seed+index, 3=seed/~seed alternating by index
seed  in  DATA_W  pattern seed
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  last run had zero mismatches; held until next start
err_count  out  ERR_W  mismatches in last run; saturates at all-ones
first_err_addr  out  ADDR_W  address of first mismatch; 0 if none
avm_address  out  ADDR_W  master address
avm_byteenable  out  DATA_W/8  all-ones whenever chipselect is high, else 0
avm_chipselect  out  1  command valid
avm_write  out  1  write command; read when low with chipselect high
avm_writedata  out  DATA_W  write data
avm_readdata  in  DATA_W  read return data
avm_waitrequest  in  1  slave stall; tie 0 for the on-chip memory

Behaviour:
- Reset (async, immediate): state IDLE; busy, done, pass, avm_chipselect, avm_write = 0. err_count, first_err_addr, avm_address, avm_writedata, avm_byteenable = 0. The read pipeline is flushed. Reset mid-run aborts with no done pulse.
- FSM states: IDLE -> WRITE -> READ -> DRAIN -> FINISH -> IDLE.
- IDLE: on start, latch base_addr, word_count, pattern_sel and seed. Clear err_count, first_err_addr and pass.
  - If word_count == 0, go to FINISH. done pulses on the cycle after start, pass=1, and there is no bus activity.
  - Otherwise go to WRITE.
- Commands are accepted on a clock edge where chipselect=1 and waitrequest=0. While waitrequest=1, address, write and writedata hold stable.
- WRITE: index i = 0..N-1 and address = (base + i) mod 2^ADDR_W, which wraps. One write per accepted cycle. After the last acceptance, go to READ with i reset to 0. There are no idle cycles between WRITE and READ.
- READ: one read per accepted cycle over the same addresses. Each acceptance pushes {valid, addr, expected} into a READ_LATENCY-deep shift pipeline. After the last acceptance, go to DRAIN.
- Compare: when a pipeline entry reaches stage READ_LATENCY, compare avm_readdata against expected.
  - On mismatch, err_count increments, saturating.
  - first_err_addr captures addr only on the first mismatch of the run.
- DRAIN: wait until the pipeline is empty, then go to FINISH.
- FINISH: done=1 for one cycle; pass = (err_count == 0 including the final compare); busy=0. Return to IDLE.
- busy is 1 from the cycle after start through DRAIN.
- Timing with waitrequest=0 and start sampled at edge k:
  - writes occupy cycles k+1..k+N;
  - reads occupy cycles k+N+1..k+2N;
  - done is high in cycle k+2N+READ_LATENCY+1.
- Pattern arithmetic:
  - seed+index is modulo 2^DATA_W.
  - {~addr,addr} zero-extends or truncates the address to DATA_W/2 per half.
- start while busy is ignored; a simultaneous start and reset_n deassertion edge is ignored.

Decomposition:
- Shared package nios_mem_bist_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN, FINISH);
  - pattern code constants PAT_CONST, PAT_ADDR, PAT_INC, PAT_CHECK;
  - max READ_LATENCY constant.
- One sub-module, nios_mem_bist_patgen: combinational, (pattern_sel, seed, index, addr) -> expected data. It is instanced once and shared by the write data path and the read-expected path.

Test Plan:
- Assert reset_n=0 mid-run with waitrequest=0 -> all outputs at reset values within the same cycle; no done pulse after release.
- base=0x0000, count=8, pattern 1, L=1 -> writes data 0xFFFF0000, 0xFFFE0001, ... to addresses 0..7, then 8 reads; done in cycle k+18; pass=1, err_count=0.
- Memory model flips bit 0 of the word at 0x0005 on readback; base=0, count=16, pattern 0, seed 0xA5A5A5A5 -> err_count=1, first_err_addr=0x0005, pass=0.
- base=0xFFFE, count=4, pattern 2, seed 0x10 -> addresses FFFE, FFFF, 0000, 0001 with data 0x10..0x13; pass=1.
- count=0 -> done the cycle after start, pass=1, chipselect never high; start pulsed during busy of a 4-word run -> ignored, exactly one done.
- Random waitrequest (50%), L=3, count=32, pattern 3 -> commands stable during stalls, 32 writes and 32 reads accepted, pass=1.
